score_ctrl: RTL and testbench

SCORE_CTRL -- requirements
Module: score_ctrl

---
 rtl/score_ctrl_pkg.sv | 16 +
 rtl/score_ctrl_bcd_inc.sv | 27 ++
 rtl/score_ctrl.sv | 132 +++++++++++++
 tb/tb_score_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/score_ctrl_pkg.sv
// Shared constants for the score display controller: FSM encodings,
// digit-cell geometry and the BCD saturation value.
package score_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  localparam logic [9:0]  ROW_OFF = 10'd24;
  localparam logic [9:0]  CELL_W  = 10'd10;
  localparam logic [9:0]  CELL_H  = 10'd20;
  localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/score_ctrl_bcd_inc.sv
// Four-digit BCD increment that holds at 9999 instead of wrapping.
module score_ctrl_bcd_inc
  import score_ctrl_pkg::*;
(
  input  logic [15:0] i_bcd,
  output logic [15:0] o_bcd
);

  always_comb begin
    logic w_carry;
    o_bcd   = i_bcd;
    w_carry = 1'b1;
    if (i_bcd != BCD_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (w_carry) begin
          if (i_bcd[4*i +: 4] == 4'd9) begin
            o_bcd[4*i +: 4] = 4'd0;
          end else begin
            o_bcd[4*i +: 4] = i_bcd[4*i +: 4] + 4'd1;
            w_carry         = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/score_ctrl.sv
// Game score/hi-score keeper with a pixel decoder that tells the segment
// renderer which digit cell the current VGA pixel falls in.
module score_ctrl
  import score_ctrl_pkg::*;
#(
  parameter logic [9:0] ORG_X = 10'd560,
  parameter logic [9:0] ORG_Y = 10'd20,
  parameter logic [9:0] PITCH = 10'd14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        start,
  input  logic        point,
  input  logic        crash,
  output logic [9:0]  segx,
  output logic [9:0]  segy,
  output logic [3:0]  num,
  output logic        digit_en,
  output logic [1:0]  state,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_bcd
);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_score, r_hi, w_score_inc;
  logic        w_enter_run, w_do_point, w_end_run;

  logic        w_row0, w_row1, w_hit, w_blank, w_en;
  logic [3:0]  w_col_hit;
  logic [1:0]  w_idx;
  logic [15:0] w_word;
  logic [9:0]  w_segx, w_segy;
  logic [3:0]  w_num;
  logic [9:0]  r_segx, r_segy;
  logic [3:0]  r_num;
  logic        r_en;

  function automatic logic [9:0] cell_x(input int i);
    return ORG_X + 10'(i) * PITCH;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (crash) w_state_nxt = ST_OVER;
      ST_OVER: if (start) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_enter_run = (w_state_nxt == ST_RUN) && (r_state != ST_RUN);
    // Crash outranks point in the same cycle, so the final score is frozen.
    w_do_point  = (r_state == ST_RUN) && point && !crash;
    w_end_run   = (r_state == ST_RUN) && crash;
  end

  score_ctrl_bcd_inc u_bcd_inc (
    .i_bcd (r_score),
    .o_bcd (w_score_inc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_score <= '0;
      r_hi    <= '0;
    end else begin
      if (w_enter_run)     r_score <= '0;
      else if (w_do_point) r_score <= w_score_inc;
      if (w_end_run && (r_score > r_hi)) r_hi <= r_score;
    end
  end

  always_comb begin
    w_row0 = (y >= ORG_Y) && (y <= ORG_Y + CELL_H - 10'd1);
    w_row1 = (y >= ORG_Y + ROW_OFF) && (y <= ORG_Y + ROW_OFF + CELL_H - 10'd1);
    for (int i = 0; i < 4; i++) begin
      w_col_hit[i] = (x >= cell_x(i)) && (x <= cell_x(i) + CELL_W - 10'd1);
    end
    w_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_col_hit[i]) w_idx = 2'(i);
    end
    w_hit  = (w_row0 || w_row1) && (w_col_hit != 4'd0);
    w_word = w_row1 ? r_hi : r_score;
    // A digit is blanked when it and every more-significant digit are zero.
    case (w_idx)
      2'd0:    w_blank = (w_word[15:12] == 4'd0);
      2'd1:    w_blank = (w_word[15:8]  == 8'd0);
      2'd2:    w_blank = (w_word[15:4]  == 12'd0);
      default: w_blank = 1'b0;
    endcase
    w_segx = '0;
    w_segy = '0;
    w_num  = '0;
    w_en   = 1'b0;
    if (w_hit) begin
      w_segx = cell_x(int'(w_idx));
      w_segy = w_row1 ? ORG_Y + ROW_OFF : ORG_Y;
      w_num  = w_word[4*(3-int'(w_idx)) +: 4];
      w_en   = !w_blank && !(w_row1 && (r_state == ST_RUN));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_segx <= '0;
      r_segy <= '0;
      r_num  <= '0;
      r_en   <= 1'b0;
    end else begin
      r_segx <= w_segx;
      r_segy <= w_segy;
      r_num  <= w_num;
      r_en   <= w_en;
    end
  end

  assign segx      = r_segx;
  assign segy      = r_segy;
  assign num       = r_num;
  assign digit_en  = r_en;
  assign state     = r_state;
  assign score_bcd = r_score;
  assign hi_bcd    = r_hi;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl: FSM, BCD scoring/saturation, hi-score
// update and the registered pixel decoder, with hand-computed expectations.
module tb_score_ctrl;

  logic        clk;
  logic        rst_n;
  logic [9:0]  x, y;
  logic        start, point, crash;
  logic [9:0]  segx, segy;
  logic [3:0]  num;
  logic        digit_en;
  logic [1:0]  state;
  logic [15:0] score_bcd, hi_bcd;

  int n_cmp;
  int n_err;

  score_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .start     (start),
    .point     (point),
    .crash     (crash),
    .segx      (segx),
    .segy      (segy),
    .num       (num),
    .digit_en  (digit_en),
    .state     (state),
    .score_bcd (score_bcd),
    .hi_bcd    (hi_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_crash();
    crash = 1'b1; step(); crash = 1'b0;
  endtask

  task automatic points(input int n);
    for (int k = 0; k < n; k++) begin
      point = 1'b1; step(); point = 1'b0;
    end
  endtask

  task automatic pix(input logic [9:0] px, input logic [9:0] py);
    x = px; y = py; step();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; point = 1'b0; crash = 1'b0;
    x = 10'd0; y = 10'd0;
    start = 1'b1; point = 1'b1; crash = 1'b1;
    step(); step();
    start = 1'b0; point = 1'b0; crash = 1'b0;
    chk("rst_state", 16'(state), 16'h0);
    chk("rst_score", score_bcd, 16'h0);
    chk("rst_hi", hi_bcd, 16'h0);
    chk("rst_en", 16'(digit_en), 16'h0);
    chk("rst_segx", 16'(segx), 16'h0);
    chk("rst_num", 16'(num), 16'h0);
    rst_n = 1'b1;

    points(3);
    chk("idle_point", score_bcd, 16'h0000);
    pulse_crash();
    chk("idle_crash", 16'(state), 16'h0);

    pulse_start();
    chk("run_state", 16'(state), 16'h1);
    chk("run_clear", score_bcd, 16'h0000);
    points(12);
    chk("score12", score_bcd, 16'h0012);
    points(30);
    chk("score42", score_bcd, 16'h0042);

    crash = 1'b1; point = 1'b1; step(); crash = 1'b0; point = 1'b0;
    chk("crash_pt_state", 16'(state), 16'h2);
    chk("crash_pt_score", score_bcd, 16'h0042);
    chk("crash_pt_hi", hi_bcd, 16'h0042);
    points(2);
    chk("over_point", score_bcd, 16'h0042);
    pulse_crash();
    chk("over_crash", 16'(state), 16'h2);

    pix(10'd588, 10'd25);
    chk("px588_segx", 16'(segx), 16'd588);
    chk("px588_segy", 16'(segy), 16'd20);
    chk("px588_num", 16'(num), 16'h4);
    chk("px588_en", 16'(digit_en), 16'h1);
    pix(10'd560, 10'd25);
    chk("px560_blank", 16'(digit_en), 16'h0);
    pix(10'd602, 10'd50);
    chk("hi_segy", 16'(segy), 16'd44);
    chk("hi_num", 16'(num), 16'h2);
    chk("hi_en", 16'(digit_en), 16'h1);
    pix(10'd571, 10'd25);
    chk("gap_en", 16'(digit_en), 16'h0);
    chk("gap_segx", 16'(segx), 16'h0);
    chk("gap_num", 16'(num), 16'h0);
    pix(10'd583, 10'd39);
    chk("edge_num", 16'(num), 16'h0);
    chk("edge_segx", 16'(segx), 16'd574);
    pix(10'd583, 10'd40);
    chk("rowgap_segy", 16'(segy), 16'h0);

    pulse_start();
    chk("restart_score", score_bcd, 16'h0000);
    pix(10'd602, 10'd50);
    chk("run_hi_en", 16'(digit_en), 16'h0);
    pix(10'd602, 10'd25);
    chk("run_d3_en", 16'(digit_en), 16'h1);
    chk("run_d3_num", 16'(num), 16'h0);

    points(30);
    pulse_start();
    chk("run_start_score", score_bcd, 16'h0030);
    chk("run_start_state", 16'(state), 16'h1);
    pulse_crash();
    chk("low_run_hi", hi_bcd, 16'h0042);

    pulse_start();
    points(999);
    chk("score999", score_bcd, 16'h0999);
    points(1);
    chk("score1000", score_bcd, 16'h1000);
    points(8999);
    chk("score9999", score_bcd, 16'h9999);
    points(1);
    chk("sat9999", score_bcd, 16'h9999);
    pulse_crash();
    chk("hi9999", hi_bcd, 16'h9999);
    pix(10'd560, 10'd63);
    chk("hi_d0_num", 16'(num), 16'h9);
    chk("hi_d0_en", 16'(digit_en), 16'h1);
    pix(10'd569, 10'd64);
    chk("below_en", 16'(digit_en), 16'h0);

    pulse_start();
    points(7);
    chk("score7", score_bcd, 16'h0007);
    x = 10'd602; y = 10'd25;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midrst_state", 16'(state), 16'h0);
    chk("midrst_score", score_bcd, 16'h0);
    chk("midrst_hi", hi_bcd, 16'h0);
    chk("midrst_en", 16'(digit_en), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
